flp_vshift_pipe: RTL and testbench
==================================

Name: flp_vshift_pipe

Overview:
- Pipelined, variable-amount shifter for the FP datapath. Successor to the fixed-amount pad-left and jam-right shifters.
- Per transaction it selects the direction: left shift with zero pad, or right shift with jam (sticky OR of shifted-out bits into the result LSB).
- Shift-amount decode is split across STAGES registered stages with valid/ready flow control. Sits between exponent-difference logic and the mantissa adder/normaliser.

Parameters:
WIDTH, 32, data width in bits (>=4)
SHW, 6, shift-amount width; amounts 0..2^SHW-1, may exceed WIDTH
STAGES, 2, pipeline register stages; SHW % STAGES == 0 (checked at elaboration)
TAGW, 4, sideband tag width carried unchanged alongside data

Ports:
clk  input  1  clock, all state on rising edge
nrst  input  1  asynchronous active-low reset
i_valid  input  1  upstream transaction valid
o_ready  output  1  block can accept (upstream ready)
i_data  input  WIDTH  operand
i_shamt  input  SHW  shift amount
i_dir  input  1  0 = left/pad-zero, 1 = right/jam
i_tag  input  TAGW  sideband tag
o_valid  output  1  result valid
i_ready  input  1  downstream ready
o_data  output  WIDTH  shifted result
o_sticky  output  1  OR of all bits discarded (right) or lost off MSB (left)
o_tag  output  TAGW  tag of the result

Behaviour:
- One clock (clk); reset asynchronous, active-low (nrst). Reset clears every stage valid bit immediately, regardless of clock.
- Reset values: o_valid=0, o_data=0, o_sticky=0, o_tag=0. o_ready=1 once nrst is high.
- Transfer in: i_valid & o_ready at a rising edge. Transfer out: o_valid & i_ready.
- Stage k (k=0..STAGES-1) applies shift-amount bits [(k+1)*G-1 : k*G], where G=SHW/STAGES. Partial shift amount = field << (k*G).
- Each stage holds valid, data, remaining shamt, dir, sticky and tag.
- Latency: exactly STAGES cycles from accept to o_valid when there is no back-pressure. Throughput: 1 per cycle.
- Flow control, per stage:
  - ready_k = !valid_k | ready_{k+1}, with ready_STAGES = i_ready.
  - o_ready = ready_0; it is combinational from i_ready through the chain, with no registered skid.
  - A stalled stage holds all its fields stable. o_data/o_tag/o_sticky must not change while o_valid & !i_ready.
- Right/jam step by amount s:
  - If s < WIDTH: d' = d >> s; lost = |d[s-1:0]; d'[0] |= lost.
  - If s >= WIDTH: d' = {0.., |d}.
  - Sticky accumulates the OR of lost.
- Left/pad step by amount s:
  - If s < WIDTH: d' = d << s; lost = |d[WIDTH-1:WIDTH-s].
  - If s >= WIDTH: d' = 0; lost = |d.
  - Sticky accumulates the OR of lost (overflow indication).
- Per-step jam is equivalent to a single jam over the full amount. The result must equal the single-shot reference for all amounts.
- shamt=0: data passes unchanged, sticky=0, latency unchanged.
- Simultaneous accept and emit in the same cycle with a full pipeline: allowed, no bubble.
- Reset mid-flight: in-flight transactions are discarded. First o_valid after reset is only for a transaction accepted after reset.
- Inputs are sampled only on accept. i_data/i_shamt/i_dir/i_tag are don't-care when i_valid=0.

Decomposition:
- Shared FP header (flp_defines.vh) holds the direction encodings FLP_SH_LEFT=0 and FLP_SH_RIGHT=1. Both this block and its bench use it.
- One natural sub-module: flp_vshift_stage, generated STAGES times.
  - Parameters: WIDTH, G, K, TAGW.
  - Contains the combinational partial shift/jam plus its valid/ready register.
- Top level holds only the generate loop and the ready chain.

Test Plan:
- Right jam, i_data=32'h1000_0001, shamt=8 -> o_data=32'h0010_0001, o_sticky=1, o_valid exactly 2 cycles after accept.
- Left pad: 32'h0000_1000 by 8 -> 32'h0010_0000, sticky=0. Then 32'h1000_0000 by 4 -> 32'h0000_0000, sticky=1.
- Oversize amounts:
  - Right 32'h0000_0001 by 40 -> 32'h0000_0001, sticky=1.
  - Right 0 by 63 -> 0, sticky=0.
  - Left 32'hFFFF_FFFF by 32 -> 0, sticky=1.
- Back-pressure: stream tags 1..5 with i_ready=0 for 4 cycles.
  - o_ready drops after 2 accepts.
  - o_data/o_tag hold for tag 1.
  - After release, tags 1..5 arrive in order, one per cycle, with no loss or duplication.
- Reset mid-flight: 2 transactions in flight, pulse nrst low for half a cycle.
  - o_valid falls immediately.
  - Nothing emerges until a new accept; the new result appears 2 cycles after it.
- Random: 10k random data/shamt/dir/tag with random i_ready, compared against a single-shot scoreboard model. Rerun with STAGES=1,3,6 and SHW=6.

Source files
------------

// File: rtl/flp_vshift_pipe_pkg.sv
// Shared definitions for the variable-amount FP shifter pipeline.
// Holds the shift-direction encodings used by the RTL and its bench,
// the default geometry, and the stage-group helper.
package flp_vshift_pipe_pkg;

  // Direction encodings (0 = left/pad-zero, 1 = right/jam)
  localparam logic FLP_SH_LEFT  = 1'b0;
  localparam logic FLP_SH_RIGHT = 1'b1;

  localparam int unsigned FLP_WIDTH_DEF  = 32;
  localparam int unsigned FLP_SHW_DEF    = 6;
  localparam int unsigned FLP_STAGES_DEF = 2;
  localparam int unsigned FLP_TAGW_DEF   = 4;

  // Shift-amount bits decoded per pipeline stage
  function automatic int unsigned flp_group(input int unsigned shw, input int unsigned stages);
    return shw / stages;
  endfunction

endpackage

// File: rtl/flp_vshift_stage.sv
// One pipeline stage of the variable shifter.
// Applies amount bits [(K+1)*G-1:K*G] (weighted by 2^(K*G)) to the incoming
// operand, left with zero pad or right with jam, and registers the result.
// Ports:
//   clk, nrst          clock, async active-low reset
//   load               this stage may capture (its ready in the chain)
//   prev_*             fields presented by the previous stage / block input
//   valid, data, shamt, dir, sticky, tag   registered stage contents
module flp_vshift_stage
  import flp_vshift_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 6,
  parameter int unsigned G     = 3,
  parameter int unsigned K     = 0,
  parameter int unsigned TAGW  = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  input  logic [SHW-1:0]   prev_shamt,
  input  logic             prev_dir,
  input  logic             prev_sticky,
  input  logic [TAGW-1:0]  prev_tag,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [SHW-1:0]   shamt,
  output logic             dir,
  output logic             sticky,
  output logic [TAGW-1:0]  tag
);

  localparam int unsigned    LO   = K * G;
  localparam logic [WIDTH-1:0] ONES = '1;

  logic [G-1:0]     field;
  logic [SHW-1:0]   amt;
  logic             oversize;
  logic [WIDTH-1:0] nxt_data;
  logic             lost;

  // Partial amount owned by this stage
  assign field    = prev_shamt[LO+G-1:LO];
  assign amt      = SHW'(field) << LO;
  assign oversize = (32'(amt) >= WIDTH);

  // Partial shift; right shifts fold the discarded bits into the LSB
  always_comb begin
    nxt_data = prev_data;
    lost     = 1'b0;
    if (prev_dir == FLP_SH_RIGHT) begin
      if (oversize) begin
        lost     = |prev_data;
        nxt_data = {{(WIDTH-1){1'b0}}, lost};
      end else begin
        lost        = |(prev_data & ~(ONES << amt));
        nxt_data    = prev_data >> amt;
        nxt_data[0] = nxt_data[0] | lost;
      end
    end else begin
      if (oversize) begin
        lost     = |prev_data;
        nxt_data = '0;
      end else begin
        lost     = |(prev_data & ~(ONES >> amt));
        nxt_data = prev_data << amt;
      end
    end
  end

  // Stage register; holds every field while stalled
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid  <= 1'b0;
      data   <= '0;
      shamt  <= '0;
      dir    <= 1'b0;
      sticky <= 1'b0;
      tag    <= '0;
    end else if (load) begin
      valid <= prev_valid;
      if (prev_valid) begin
        data   <= nxt_data;
        shamt  <= prev_shamt;
        dir    <= prev_dir;
        sticky <= prev_sticky | lost;
        tag    <= prev_tag;
      end
    end
  end

endmodule

// File: rtl/flp_vshift_pipe.sv
// Pipelined variable-amount shifter (left/pad-zero or right/jam) with
// valid/ready flow control and a sideband tag.
// Ports:
//   clk, nrst                       clock, async active-low reset
//   i_valid/o_ready                 upstream handshake (o_ready combinational)
//   i_data, i_shamt, i_dir, i_tag   transaction fields, sampled on accept
//   o_valid/i_ready                 downstream handshake
//   o_data, o_sticky, o_tag         registered result
module flp_vshift_pipe
  import flp_vshift_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = FLP_WIDTH_DEF,
  parameter int unsigned SHW    = FLP_SHW_DEF,
  parameter int unsigned STAGES = FLP_STAGES_DEF,
  parameter int unsigned TAGW   = FLP_TAGW_DEF
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [SHW-1:0]   i_shamt,
  input  logic             i_dir,
  input  logic [TAGW-1:0]  i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_sticky,
  output logic [TAGW-1:0]  o_tag
);

  localparam int unsigned G = flp_group(SHW, STAGES);

  if ((SHW % STAGES) != 0) begin : g_bad_split
    $error("flp_vshift_pipe: SHW must be a multiple of STAGES");
  end
  if (WIDTH < 4) begin : g_bad_width
    $error("flp_vshift_pipe: WIDTH must be at least 4");
  end

  // Index 0 is the block input, index k+1 the register of stage k
  logic [STAGES:0] v;
  logic [STAGES:0] dr;
  logic [STAGES:0] st;
  logic [WIDTH-1:0] dat [STAGES+1];
  logic [SHW-1:0]   sh  [STAGES+1];
  logic [TAGW-1:0]  tg  [STAGES+1];
  logic [STAGES-1:0] rdy;
  logic acc;
  logic unused_tail;

  assign v[0]   = i_valid;
  assign dat[0] = i_data;
  assign sh[0]  = i_shamt;
  assign dr[0]  = i_dir;
  assign st[0]  = 1'b0;
  assign tg[0]  = i_tag;

  // Ready chain: a stage can load when empty or when its successor can
  always_comb begin
    acc = i_ready;
    rdy = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      acc    = ~v[k+1] | acc;
      rdy[k] = acc;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    flp_vshift_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .G     (G),
      .K     (k),
      .TAGW  (TAGW)
    ) u_stage (
      .clk         (clk),
      .nrst        (nrst),
      .load        (rdy[k]),
      .prev_valid  (v[k]),
      .prev_data   (dat[k]),
      .prev_shamt  (sh[k]),
      .prev_dir    (dr[k]),
      .prev_sticky (st[k]),
      .prev_tag    (tg[k]),
      .valid       (v[k+1]),
      .data        (dat[k+1]),
      .shamt       (sh[k+1]),
      .dir         (dr[k+1]),
      .sticky      (st[k+1]),
      .tag         (tg[k+1])
    );
  end

  // Amount and direction are not needed past the last stage
  assign unused_tail = ^{sh[STAGES], dr[STAGES]};

  assign o_ready  = rdy[0];
  assign o_valid  = v[STAGES];
  assign o_data   = dat[STAGES];
  assign o_sticky = st[STAGES];
  assign o_tag    = tg[STAGES];

endmodule

// File: tb/tb_flp_vshift_pipe.sv
// Self-checking bench for flp_vshift_pipe: directed cases, back-pressure,
// mid-flight reset and a randomized stream scored against a bit-level model.
module tb_flp_vshift_pipe;
  import flp_vshift_pipe_pkg::*;

  localparam int unsigned W      = 32;
  localparam int unsigned SHW    = 6;
  localparam int unsigned STAGES = 2;
  localparam int unsigned TAGW   = 4;
  localparam int unsigned N_RAND = 10000;

  typedef struct {
    logic [W-1:0]    d;
    logic            s;
    logic [TAGW-1:0] t;
  } exp_t;

  logic            clk;
  logic            nrst;
  logic            i_valid;
  logic            o_ready;
  logic [W-1:0]    i_data;
  logic [SHW-1:0]  i_shamt;
  logic            i_dir;
  logic [TAGW-1:0] i_tag;
  logic            o_valid;
  logic            i_ready;
  logic [W-1:0]    o_data;
  logic            o_sticky;
  logic [TAGW-1:0] o_tag;

  int n_checks = 0;
  int n_pass   = 0;
  int n_acc    = 0;
  int cyc      = 0;
  exp_t sb[$];
  int   emit_cyc[$];
  int   emit_tag[$];

  flp_vshift_pipe #(
    .WIDTH (W), .SHW (SHW), .STAGES (STAGES), .TAGW (TAGW)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_data   (i_data),
    .i_shamt  (i_shamt),
    .i_dir    (i_dir),
    .i_tag    (i_tag),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_sticky (o_sticky),
    .o_tag    (o_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Single-shot reference: every source bit either lands in the result or is lost
  function automatic exp_t ref_shift(input logic [W-1:0] d, input logic [SHW-1:0] s,
                                     input logic dir, input logic [TAGW-1:0] t);
    exp_t r;
    int amt;
    amt = int'(s);
    r.d = '0;
    r.s = 1'b0;
    r.t = t;
    for (int i = 0; i < int'(W); i++) begin
      if (dir == FLP_SH_RIGHT) begin
        if (i < amt) r.s = r.s | d[i];
        else         r.d[i-amt] = d[i];
      end else begin
        if (i + amt >= int'(W)) r.s = r.s | d[i];
        else                    r.d[i+amt] = d[i];
      end
    end
    if (dir == FLP_SH_RIGHT) r.d[0] = r.d[0] | r.s;
    return r;
  endfunction

  // Called at a negedge with inputs driven; scores this cycle, returns at next negedge
  task automatic tick();
    exp_t tmp;
    #1;
    if (o_valid) begin
      if (sb.size() == 0) check("unexpected_valid", 64'(o_valid), 64'd0);
      else begin
        check("data", 64'(o_data), 64'(sb[0].d));
        check("stk_tag", 64'({o_sticky, o_tag}), 64'({sb[0].s, sb[0].t}));
      end
    end
    if (o_valid && i_ready && sb.size() > 0) begin
      tmp = sb.pop_front();
      emit_cyc.push_back(cyc);
      emit_tag.push_back(int'(o_tag));
    end
    if (i_valid && o_ready) begin
      sb.push_back(ref_shift(i_data, i_shamt, i_dir, i_tag));
      n_acc++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // One isolated transaction; latency counts edges from the accepting edge
  task automatic run_one(input string nm, input logic [W-1:0] d, input logic [SHW-1:0] s,
                         input logic dir, input logic [TAGW-1:0] t,
                         input logic [W-1:0] ed, input logic es);
    int lat;
    @(negedge clk);
    i_valid = 1'b1; i_data = d; i_shamt = s; i_dir = dir; i_tag = t; i_ready = 1'b1;
    #1;
    check({nm, "_ready"}, 64'(o_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_latency"}, 64'(lat), 64'(STAGES));
    check({nm, "_data"}, 64'(o_data), 64'(ed));
    check({nm, "_sticky"}, 64'(o_sticky), 64'(es));
    check({nm, "_tag"}, 64'(o_tag), 64'(t));
    @(negedge clk);
    check({nm, "_drop"}, 64'(o_valid), 64'd0);
  endtask

  initial begin
    int tag_next;
    int a0;
    int c;

    nrst = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_data = '0; i_shamt = '0; i_dir = 1'b0; i_tag = '0;

    // Reset state
    #7;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_data", 64'(o_data), 64'd0);
    check("rst_sticky", 64'(o_sticky), 64'd0);
    check("rst_tag", 64'(o_tag), 64'd0);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    check("rst_ready", 64'(o_ready), 64'd1);

    // Directed shifts
    run_one("rjam", 32'h1000_0001, 6'd8,  FLP_SH_RIGHT, 4'h3, 32'h0010_0001, 1'b1);
    run_one("lpad", 32'h0000_1000, 6'd8,  FLP_SH_LEFT,  4'h4, 32'h0010_0000, 1'b0);
    run_one("lovf", 32'h1000_0000, 6'd4,  FLP_SH_LEFT,  4'h5, 32'h0000_0000, 1'b1);
    run_one("r40",  32'h0000_0001, 6'd40, FLP_SH_RIGHT, 4'h6, 32'h0000_0001, 1'b1);
    run_one("r63z", 32'h0000_0000, 6'd63, FLP_SH_RIGHT, 4'h7, 32'h0000_0000, 1'b0);
    run_one("l32",  32'hFFFF_FFFF, 6'd32, FLP_SH_LEFT,  4'h8, 32'h0000_0000, 1'b1);
    run_one("zero", 32'hDEAD_BEEF, 6'd0,  FLP_SH_RIGHT, 4'h9, 32'hDEAD_BEEF, 1'b0);
    run_one("r31",  32'h8000_0000, 6'd31, FLP_SH_RIGHT, 4'hA, 32'h0000_0001, 1'b0);
    run_one("r32",  32'h8000_0000, 6'd32, FLP_SH_RIGHT, 4'hB, 32'h0000_0001, 1'b1);
    run_one("l31",  32'h0000_0003, 6'd31, FLP_SH_LEFT,  4'hC, 32'h8000_0000, 1'b1);

    // Back-pressure: tags 1..5, downstream stalled for the first 4 cycles
    @(negedge clk);
    sb.delete(); emit_cyc.delete(); emit_tag.delete();
    n_acc = 0; tag_next = 1;
    for (c = 0; c < 40 && emit_tag.size() < 5; c++) begin
      i_ready = (c >= 4);
      i_valid = (tag_next <= 5);
      i_tag   = TAGW'(tag_next);
      i_data  = W'($urandom());
      i_shamt = SHW'($urandom());
      i_dir   = 1'($urandom());
      #1;
      if (c >= 2 && c <= 3) check("bp_hold_tag", 64'(o_tag), 64'd1);
      if (c == 3) begin
        check("bp_accepts", 64'(n_acc), 64'(STAGES));
        check("bp_ready_low", 64'(o_ready), 64'd0);
      end
      a0 = n_acc;
      tick();
      if (n_acc != a0) tag_next++;
    end
    i_valid = 1'b0;
    check("bp_count", 64'(emit_tag.size()), 64'd5);
    for (int i = 0; i < emit_tag.size(); i++) begin
      check("bp_order", 64'(emit_tag[i]), 64'(i + 1));
      if (i > 0) check("bp_gap", 64'(emit_cyc[i] - emit_cyc[i-1]), 64'd1);
    end

    // Reset mid-flight with two transactions in the pipe
    sb.delete();
    i_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      i_valid = 1'b1; i_data = W'($urandom()); i_shamt = SHW'($urandom());
      i_dir = 1'($urandom()); i_tag = TAGW'(12 + i);
      tick();
    end
    i_valid = 1'b0;
    #1;
    check("mid_valid_before", 64'(o_valid), 64'd1);
    nrst = 1'b0;
    #1;
    check("mid_valid_async", 64'(o_valid), 64'd0);
    check("mid_data_async", 64'(o_data), 64'd0);
    #2;
    nrst = 1'b1;
    sb.delete();
    i_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("mid_idle", 64'(o_valid), 64'd0);
      tick();
    end
    run_one("post_rst", 32'h0F00_00F0, 6'd4, FLP_SH_RIGHT, 4'h2, 32'h00F0_000F, 1'b0);

    // Randomized stream with random back-pressure
    @(negedge clk);
    sb.delete();
    n_acc = 0;
    for (c = 0; c < 60000 && n_acc < int'(N_RAND); c++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
      i_data  = ($urandom_range(0, 3) == 0) ? W'(32'h1 << $urandom_range(0, 31)) : W'($urandom());
      i_shamt = SHW'($urandom_range(0, (1 << SHW) - 1));
      i_dir   = 1'($urandom());
      i_tag   = TAGW'($urandom());
      tick();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (c = 0; c < 20 && sb.size() > 0; c++) tick();
    check("rand_accepts", 64'(n_acc), 64'(N_RAND));
    check("rand_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
